// File: rtl/rotate_align.sv
// rotate_align
// Recovers an unknown right rotation. On an accepted start it captures a
// word and a reference pattern, then rotates the word right one bit per
// cycle until it equals the pattern. It reports the smallest matching
// rotation amount, or that no rotation of the word matches.
//
// Ports
//   clock      : single clock, all state updates on posedge
//   reset_n    : asynchronous active-low reset
//   start_i    : request a search, sampled only while idle
//   word_i     : rotated word to analyse, captured on accepted start
//   pattern_i  : reference word, captured on accepted start
//   busy_o     : high while searching and during the done cycle
//   done_o     : one-cycle pulse marking the result cycle
//   found_o    : a rotation matched (valid from done until next start)
//   amount_o   : number of right rotations of word that equal pattern
module rotate_align #(
    parameter  int N  = 4,
    localparam int AW = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic [N-1:0]  word_i,
    input  logic [N-1:0]  pattern_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          found_o,
    output logic [AW-1:0] amount_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  w_q, w_d;
    logic [N-1:0]  p_q, p_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          found_q, found_d;
    logic [AW-1:0] amount_q, amount_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            w_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            amount_q <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            found_q  <= found_d;
            amount_q <= amount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        found_d  = found_q;
        amount_d = amount_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    w_d      = word_i;
                    p_d      = pattern_i;
                    cnt_d    = '0;
                    found_d  = 1'b0;
                    amount_d = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                // Candidates are tested in increasing rotation order, so
                // the first hit is the smallest amount for periodic words.
                if (w_q == p_q) begin
                    found_d  = 1'b1;
                    amount_d = cnt_q;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    found_d  = 1'b0;
                    amount_d = '0;
                    state_d  = DONE;
                end else begin
                    w_d   = {w_q[0], w_q[N-1:1]};
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no input-to-output paths.
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign found_o  = found_q;
    assign amount_o = amount_q;

endmodule

// File: tb/tb_rotate_align.sv
module tb_rotate_align;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic [N-1:0]  word_i;
    logic [N-1:0]  pattern_i;
    logic          busy_o;
    logic          done_o;
    logic          found_o;
    logic [AW-1:0] amount_o;

    int total = 0;
    int bad   = 0;

    rotate_align #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_i   (start_i),
        .word_i    (word_i),
        .pattern_i (pattern_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .found_o   (found_o),
        .amount_o  (amount_o)
    );

    always #5 clock = ~clock;

    function automatic logic [N-1:0] rotr(input logic [N-1:0] w, input int r);
        logic [2*N-1:0] dbl;
        dbl = {w, w} >> r;
        return dbl[N-1:0];
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] w, input int r);
        return rotr(w, (N - r) % N);
    endfunction

    // Behavioural model: on accept, find the smallest r with rotr(word,r)
    // == pattern; latency is r+1 (or N with no match). Outputs follow from
    // the elapsed edge count since acceptance.
    bit          m_active;
    int          m_e, m_lat, m_ra;
    bit          m_rf, m_found;
    int          m_amt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_e = 0; m_lat = 0;
            m_found = 0; m_amt = 0; m_rf = 0; m_ra = 0;
        end else if (m_active) begin
            m_e++;
            if (m_e == m_lat) begin
                m_found = m_rf;
                m_amt   = m_ra;
            end
            if (m_e == m_lat + 1) m_active = 0;
        end else if (start_i) begin
            m_rf = 0; m_ra = 0; m_lat = N;
            for (int r = N - 1; r >= 0; r--) begin
                if (rotr(word_i, r) == pattern_i) begin
                    m_rf = 1; m_ra = r; m_lat = r + 1;
                end
            end
            m_active = 1; m_e = 0; m_found = 0; m_amt = 0;
        end
    end

    always @(negedge clock) begin
        logic eb, ed;
        eb = m_active;
        ed = m_active && (m_e == m_lat);
        total++;
        if (busy_o !== eb || done_o !== ed || found_o !== m_found ||
            amount_o !== AW'(m_amt)) begin
            bad++;
            $display("FAIL cycle_model t=%0t got busy=%b done=%b found=%b amount=%0d want busy=%b done=%b found=%b amount=%0d",
                     $time, busy_o, done_o, found_o, amount_o, eb, ed, m_found, m_amt);
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done_o !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    // Accept a search, scramble the inputs, wait for done, check result
    // and latency against hand-computed values, then step back to idle.
    task automatic search(input logic [N-1:0] w, input logic [N-1:0] p,
                          input int ef, input int ea, input int elat,
                          input string name);
        int n;
        start_i = 1'b1; word_i = w; pattern_i = p;
        @(posedge clock); #1;
        start_i = 1'b0; word_i = N'($urandom); pattern_i = N'($urandom);
        wait_done(0, n);
        check({name, "_latency"}, n, elat);
        check({name, "_found"}, int'(found_o), ef);
        check({name, "_amount"}, int'(amount_o), ea);
        @(posedge clock); #1;
    endtask

    initial begin
        int n, dones;
        reset_n = 1'b0; start_i = 1'b1; word_i = 4'b0001; pattern_i = 4'b0001;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", int'({busy_o, done_o, found_o, amount_o}), 0);
        reset_n = 1'b1;
        search(4'b0001, 4'b0001, 1, 0, 1, "eq0");

        search(4'b0001, 4'b1000, 1, 1, 2, "shift1");
        search(4'b0001, 4'b0100, 1, 2, 3, "shift2");
        search(4'b0001, 4'b0010, 1, 3, 4, "shift3");
        repeat (3) @(posedge clock);
        #1;
        check("idle_hold_found", int'(found_o), 1);
        check("idle_hold_amount", int'(amount_o), 3);

        search(4'b0001, 4'b0011, 0, 0, 4, "nomatch");
        search(4'b1010, 4'b0101, 1, 1, 2, "periodic1010");
        search(4'b1111, 4'b1111, 1, 0, 1, "ones");
        search(4'b0000, 4'b0000, 1, 0, 1, "zeros");
        search(4'b0110, 4'b1111, 0, 0, 4, "nomatch2");

        // Second start one cycle after acceptance must be ignored.
        start_i = 1'b1; word_i = 4'b0001; pattern_i = 4'b1000;
        @(posedge clock); #1;
        word_i = 4'b0001; pattern_i = 4'b0001;
        @(posedge clock); #1;
        start_i = 1'b0;
        wait_done(1, n);
        check("ignore_latency", n, 2);
        check("ignore_amount", int'(amount_o), 1);
        @(posedge clock); #1;

        // Start held high: accepts at edges 0,5,10,15 -> dones after 3,8,13.
        dones = 0;
        start_i = 1'b1; word_i = 4'b0001; pattern_i = 4'b0100;
        for (int i = 0; i < 18; i++) begin
            @(posedge clock); #1;
            if (done_o === 1'b1) dones++;
        end
        start_i = 1'b0;
        check("backtoback_dones", dones, 3);
        n = 0;
        while (busy_o === 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("backtoback_drain", int'(n < 20), 1);

        // Reset in the middle of a search.
        start_i = 1'b1; word_i = 4'b0001; pattern_i = 4'b0011;
        @(posedge clock); #1;
        start_i = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", int'({busy_o, done_o, found_o, amount_o}), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        search(4'b0001, 4'b1000, 1, 1, 2, "after_reset");

        // Loopback: rotate-left by k is undone by k right rotations.
        for (int k = 0; k < N; k++) begin
            search(rotl(4'b0001, k), 4'b0001, 1, k, k + 1, $sformatf("loop%0d", k));
        end

        repeat (2) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
